// File: rtl/lram_rom_arb_pkg.sv
// Shared types and constants for the LUTRAM ROM round-robin arbiter.
package lram_rom_arb_pkg;
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int MAX_NREQ = 4;
    // Wide enough to index MAX_NREQ requesters
    localparam int PTR_W    = 2;
endpackage

// File: rtl/lram_rom_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick
    import lram_rom_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] index
);
    logic found_s;

    // Visit positions ptr, ptr+1, ... mod NREQ and latch the first valid one.
    always_comb begin
        grant   = '0;
        index   = '0;
        found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found_s && valid[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    grant[i] = 1'b1;
                    index    = PTR_W'(i);
                    found_s  = 1'b1;
                end else begin
                    found_s  = found_s;
                end
            end
        end
    end
endmodule

// File: rtl/lram_rom_arb.sv
// Round-robin arbiter sharing one LUTRAM ROM read port, with lockable bursts
// and a fixed-latency tag pipeline that returns one-hot tagged read data.
module lram_rom_arb
    import lram_rom_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AW     = 3,
    parameter int DW     = 8,
    parameter int RD_LAT = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]   req_ready,
    output logic [AW-1:0]     rom_addr,
    input  logic [DW-1:0]     rom_data,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data
);
    arb_state_t       state_r;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] owner_r;
    logic [NREQ-1:0]  tag_r [RD_LAT+1];

    logic [NREQ-1:0]  pick_grant_s;
    logic [PTR_W-1:0] pick_idx_s;
    logic [NREQ-1:0]  ready_s;
    logic [PTR_W-1:0] win_idx_s;
    logic [PTR_W-1:0] ptr_next_s;
    logic             lock_s;
    logic             accept_s;
    logic [AW-1:0]    sel_addr_s;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .index (pick_idx_s)
    );

    // Grant selection: picker result when arbitrating, owner-only when locked.
    always_comb begin
        ready_s    = '0;
        win_idx_s  = '0;
        lock_s     = 1'b0;
        sel_addr_s = '0;
        case (state_r)
            ARB: begin
                ready_s   = pick_grant_s;
                win_idx_s = pick_idx_s;
            end
            LOCKED: begin
                win_idx_s = owner_r;
                for (int i = 0; i < NREQ; i++) begin
                    ready_s[i] = req_valid[i] & (owner_r == PTR_W'(i));
                end
            end
            default: begin
                ready_s   = '0;
                win_idx_s = '0;
            end
        endcase
        for (int i = 0; i < NREQ; i++) begin
            lock_s     = lock_s | (req_lock[i] & (win_idx_s == PTR_W'(i)));
            sel_addr_s = sel_addr_s | ({AW{ready_s[i]}} & req_addr[i*AW +: AW]);
        end
        accept_s   = |ready_s;
        ptr_next_s = (win_idx_s == PTR_W'(NREQ - 1)) ? '0 : win_idx_s + PTR_W'(1);
    end

    assign req_ready = ready_s;

    // Arbitration state, rotation pointer and lock owner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ARB;
            ptr_r   <= '0;
            owner_r <= '0;
        end else begin
            case (state_r)
                ARB: begin
                    if (accept_s) begin
                        ptr_r <= ptr_next_s;
                        if (lock_s) begin
                            state_r <= LOCKED;
                            owner_r <= win_idx_s;
                        end
                    end
                end
                LOCKED: begin
                    // Leaving needs only lock low: with valid high that is the final beat
                    if (!lock_s) begin
                        state_r <= ARB;
                    end
                end
                default: state_r <= ARB;
            endcase
        end
    end

    // ROM address, tag pipeline and registered response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_addr  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            if (accept_s) begin
                rom_addr <= sel_addr_s;
            end
            tag_r[0] <= ready_s;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
            rsp_valid <= tag_r[RD_LAT];
            if (|tag_r[RD_LAT]) begin
                rsp_data <= rom_data;
            end
        end
    end
endmodule

// File: doc/lram_rom_arb.md
# lram_rom_arb

Round-robin arbiter that shares one LUTRAM ROM read port (the `main` ROM: `addr` in, `y` out) between NREQ requesters. Each requester presents an address with a valid/ready handshake. The arbiter drives the ROM address, tracks in-flight reads through a fixed-latency pipeline, and returns the data tagged with a one-hot requester id. An optional lock lets one requester hold the port for back-to-back burst reads.

## Interface
- NREQ, 2: number of requesters (2..4).
- AW, 3: ROM address width.
- DW, 8: ROM data width.
- RD_LAT, 0: ROM read latency in cycles after `rom_addr` changes (0 = asynchronous LUTRAM read; legal range 0..2).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NREQ  per-requester read request.
- req_lock  in  NREQ  hold ownership after this beat.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_ready  out  NREQ  one-hot grant; handshake completes when `req_valid[i] & req_ready[i]`.
- rom_addr  out  AW  registered address to the ROM.
- rom_data  in  DW  ROM read data.
- rsp_valid  out  NREQ  one-hot, single-cycle response strobe.
- rsp_data  out  DW  read data, valid while any `rsp_valid` bit is set.

## Operation
- States: ARB and LOCKED(owner). Reset enters ARB with priority pointer `ptr` = 0.
- ARB:
  - Winner = first i with `req_valid[i]`, searching i = ptr, ptr+1, ... mod NREQ.
  - `req_ready` = one-hot of the winner, or 0 if no request is valid. `req_ready[i]` is never 1 while `req_valid[i]` is 0.
  - On accept, `ptr` <= winner+1 mod NREQ.
  - If `req_lock[winner]` = 1 at accept, go to LOCKED(winner).
- LOCKED(o):
  - `req_ready` = `req_valid[o]` at bit o; all other bits are 0.
  - An accept with `req_lock[o]` = 0 returns to ARB.
  - `req_valid[o]` = 0 with `req_lock[o]` = 0 also returns to ARB, with no accept.
  - `ptr` stays at o+1.
- Every accept loads `rom_addr` <= `req_addr[winner]` and pushes the one-hot id into an (RD_LAT+1)-deep tag shift register. Bubbles push 0.
- The tag at pipeline exit registers `rsp_valid` <= tag and `rsp_data` <= `rom_data`. `rsp_data` holds its last value when there is no response.
- There is no response backpressure: requesters must sink `rsp_valid` unconditionally.
- Throughput is one accept per cycle.

## Timing
- Reset values: `req_ready` = 0 (combinational, with all valids low); `rom_addr` = 0; `rsp_valid` = 0; `rsp_data` = 0; tag pipeline = 0; state ARB; `ptr` = 0.
- Latency: accept at edge E gives `rsp_valid` high for one cycle after edge E+1+RD_LAT.
- `req_ready` is a combinational function of `req_valid`, `req_lock`, state and `ptr`. There is no combinational path from `rom_data` to any output.
- Reset asserted mid-operation: all in-flight tags are dropped, no late `rsp_valid` appears, and lock ownership is released.
- `ptr` wraps from NREQ-1 to 0.
- All requesters valid simultaneously: strict rotation, one grant each per NREQ cycles, unless a lock is held.
- A lock asserted by a non-winner has no effect.

## Structure
- Package `lram_rom_arb_pkg`: state enum `arb_state_t` {ARB, LOCKED} and constant `MAX_NREQ` = 4.
- Sub-module `rr_pick`: combinational round-robin priority picker with inputs (valid[NREQ], ptr) and outputs (one-hot grant, index). It is instantiated once.
- The tag pipeline and state register live in the top module.

## Test plan
Bench ROM model: `rom[a]` = 8'h10 + a, with RD_LAT = 0 and NREQ = 2.
- Reset release with no requests: `req_ready` = 0, `rsp_valid` = 0, `rom_addr` = 0 for 5 cycles.
- Single read: r0 requests addr 3 and is accepted at edge E. Required: `rsp_valid` = 2'b01 and `rsp_data` = 8'h13 after edge E+1, for exactly one cycle.
- Contention: r0 and r1 both hold valid continuously with addrs 1 and 2. Required: grants alternate r0, r1, r0, ...; responses alternate 8'h11 and 8'h12 with matching one-hot ids.
- Lock burst: r1 wins with lock = 1 and sends addrs 4, 5, 6, with lock = 0 on 6, while r0 is valid throughout. Required: three consecutive r1 accepts, then r0 is granted next.
- Reset mid-flight: assert reset one cycle after an accept. Required: no `rsp_valid` for that read; state ARB and `ptr` = 0 after release.
- Wrap and latency: rerun with NREQ = 3, RD_LAT = 2 and all valid. Required: grant order r0, r1, r2, r0, and every response arrives exactly 3 cycles after its accept.
